// File: rtl/tx_rd_addr_commit_ctrl.sv
// TX committed read address scheduler: arbitrates two release streams, accumulates them and
// publishes the address toward the clk_in synchronizer at most once per HOLDOFF cycles.
// Optional counters publish_cnt/rel_cnt are enabled by defining TX_RD_ADDR_CTRL_STATS_EN.
module tx_rd_addr_commit_ctrl #(
    parameter int AW      = 12,
    parameter int LW      = 8,
    parameter int HOLDOFF = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          rel0_valid,
    input  logic [LW-1:0] rel0_len,
    output logic          rel0_ready,
    input  logic          rel1_valid,
    input  logic [LW-1:0] rel1_len,
    output logic          rel1_ready,
    input  logic          flush,
    output logic [AW-1:0] commited_rd_addr,
    output logic          pending
`ifdef TX_RD_ADDR_CTRL_STATS_EN
    ,
    output logic [31:0]   publish_cnt,
    output logic [31:0]   rel_cnt
`endif
);

    localparam int HW = (HOLDOFF > 2) ? $clog2(HOLDOFF) : 1;
    localparam logic [AW-1:0] FULL_TH = AW'((1 << (AW - 1)) - (1 << LW));

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t        state, state_n;
    logic [AW-1:0] acc_addr, acc_addr_n;
    logic [AW-1:0] com_n;
    logic [HW-1:0] hcnt, hcnt_n;
    logic          rr, rr_n;
    logic          flush_pend, flush_pend_n;
    logic          pending_n;
    logic [AW-1:0] diff;
    logic          full;
    logic          grant0, grant1;
    logic          publish;

    always_comb begin
        diff   = acc_addr - commited_rd_addr;
        full   = (diff >= FULL_TH);
        grant0 = reset_n && !full && rel0_valid && (!rel1_valid || !rr);
        grant1 = reset_n && !full && rel1_valid && (!rel0_valid || rr);
    end

    assign rel0_ready = grant0;
    assign rel1_ready = grant1;

    always_comb begin
        acc_addr_n   = acc_addr;
        rr_n         = rr;
        state_n      = state;
        hcnt_n       = hcnt;
        com_n        = commited_rd_addr;
        flush_pend_n = flush_pend | flush;
        publish      = 1'b0;

        if (grant0) begin
            acc_addr_n = acc_addr + AW'(rel0_len);
        end else if (grant1) begin
            acc_addr_n = acc_addr + AW'(rel1_len);
        end
        if (rel0_valid && rel1_valid && (grant0 || grant1)) begin
            rr_n = ~rr;
        end

        case (state)
            S_IDLE: begin
                if ((acc_addr != commited_rd_addr) || flush_pend) begin
                    publish      = 1'b1;
                    com_n        = acc_addr;
                    hcnt_n       = HW'(HOLDOFF - 1);
                    flush_pend_n = 1'b0;
                    state_n      = S_HOLD;
                end
            end
            S_HOLD: begin
                // Leave as the count reaches zero so the next publish lands exactly HOLDOFF cycles later.
                hcnt_n = hcnt - 1'b1;
                if (hcnt <= HW'(1)) begin
                    hcnt_n  = '0;
                    state_n = S_IDLE;
                end
            end
            default: begin
                state_n = S_IDLE;
                hcnt_n  = '0;
            end
        endcase

        pending_n = (acc_addr_n != com_n);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= S_IDLE;
            acc_addr         <= '0;
            commited_rd_addr <= '0;
            hcnt             <= '0;
            rr               <= 1'b0;
            flush_pend       <= 1'b0;
            pending          <= 1'b0;
        end else begin
            state            <= state_n;
            acc_addr         <= acc_addr_n;
            commited_rd_addr <= com_n;
            hcnt             <= hcnt_n;
            rr               <= rr_n;
            flush_pend       <= flush_pend_n;
            pending          <= pending_n;
        end
    end

`ifdef TX_RD_ADDR_CTRL_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            publish_cnt <= '0;
            rel_cnt     <= '0;
        end else begin
            if (publish) begin
                publish_cnt <= publish_cnt + 32'd1;
            end
            if (grant0 || grant1) begin
                rel_cnt <= rel_cnt + 32'd1;
            end
        end
    end
`else
    logic unused_publish;
    assign unused_publish = publish;
`endif

endmodule

// File: tb/tb_tx_rd_addr_commit_ctrl.sv
// Directed + randomized bench for tx_rd_addr_commit_ctrl against a cycle-count reference model.
module tb_tx_rd_addr_commit_ctrl;

    localparam int AW         = 12;
    localparam int LW         = 8;
    localparam int HOLDOFF    = 8;
    localparam int FULL_LIMIT = 2 ** (AW - 1) - 2 ** LW;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          rel0_valid = 1'b0;
    logic [LW-1:0] rel0_len = '0;
    logic          rel0_ready;
    logic          rel1_valid = 1'b0;
    logic [LW-1:0] rel1_len = '0;
    logic          rel1_ready;
    logic          flush = 1'b0;
    logic [AW-1:0] commited_rd_addr;
    logic          pending;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: byte total, published value, and cycle of the last publish.
    logic [AW-1:0] m_acc = '0;
    logic [AW-1:0] m_com = '0;
    bit            m_rr  = 1'b0;
    bit            m_fp  = 1'b0;
    longint        cyc      = 0;
    longint        last_pub = -HOLDOFF;
    logic          last_r0;

    tx_rd_addr_commit_ctrl #(.AW(AW), .LW(LW), .HOLDOFF(HOLDOFF)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .rel0_valid       (rel0_valid),
        .rel0_len         (rel0_len),
        .rel0_ready       (rel0_ready),
        .rel1_valid       (rel1_valid),
        .rel1_len         (rel1_len),
        .rel1_ready       (rel1_ready),
        .flush            (flush),
        .commited_rd_addr (commited_rd_addr),
        .pending          (pending)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit v0, input logic [LW-1:0] l0, input bit v1,
                        input logic [LW-1:0] l1, input bit fl, output bit g0, output bit g1);
        logic [AW-1:0] diff;
        bit full, pub;
        @(negedge clk);
        rel0_valid = v0; rel0_len = l0; rel1_valid = v1; rel1_len = l1; flush = fl;
        #1;
        last_r0 = rel0_ready;
        diff = m_acc - m_com;
        full = int'(diff) >= FULL_LIMIT;
        g0 = 1'b0; g1 = 1'b0;
        if (!full) begin
            if (v0 && v1) begin
                if (m_rr) g1 = 1'b1; else g0 = 1'b1;
                m_rr = ~m_rr;
            end else if (v0) g0 = 1'b1;
            else if (v1) g1 = 1'b1;
        end
        chk("rel0_ready", 32'(rel0_ready), 32'(g0));
        chk("rel1_ready", 32'(rel1_ready), 32'(g1));
        pub = (cyc - last_pub >= HOLDOFF) && ((m_acc != m_com) || m_fp);
        if (pub) begin
            m_com = m_acc; last_pub = cyc; m_fp = 1'b0;
        end else if (fl) m_fp = 1'b1;
        if (g0) m_acc = m_acc + AW'(l0);
        if (g1) m_acc = m_acc + AW'(l1);
        @(posedge clk);
        #1;
        cyc++;
        chk("commited_rd_addr", 32'(commited_rd_addr), 32'(m_com));
        chk("pending", 32'(pending), 32'(m_acc != m_com));
    endtask

    task automatic idle(input int n);
        bit g0, g1;
        for (int i = 0; i < n; i++) step(0, '0, 0, '0, 0, g0, g1);
    endtask

    task automatic send(input bit port, input logic [LW-1:0] len);
        bit g0, g1, done;
        int n;
        n = 0; done = 0;
        while (!done && n < 64) begin
            step(!port, len, port, len, 0, g0, g1);
            done = port ? g1 : g0;
            n++;
        end
        chk("send_accepted", 32'(done), 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rel0_valid = 1'b1; rel1_valid = 1'b1; flush = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("rst_com", 32'(commited_rd_addr), 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_ready", 32'({rel0_ready, rel1_ready}), 32'd0);
        repeat (2) @(negedge clk);
        rel0_valid = 1'b0; rel1_valid = 1'b0;
        reset_n = 1'b1;
        m_acc = '0; m_com = '0; m_rr = 1'b0; m_fp = 1'b0; last_pub = cyc - HOLDOFF;
    endtask

    initial begin
        bit g0, g1, saw_block, saw_reassert, a0, a1;
        int grants[$];
        int r0, r1;
        longint last_change;
        logic [AW-1:0] prev;
        logic [LW-1:0] q0, q1;

        // Single release
        do_reset();
        idle(5);
        send(0, 8'h40);
        idle(1);
        chk("single_publish", 32'(commited_rd_addr), 32'h040);
        idle(8);
        chk("single_stable", 32'(commited_rd_addr), 32'h040);

        // Spacing under continuous work
        do_reset();
        prev = commited_rd_addr; last_change = -1;
        for (int i = 0; i < 30; i++) begin
            step(1, 8'h10, 0, '0, 0, g0, g1);
            if (commited_rd_addr != prev) begin
                if (last_change >= 0) chk("spacing", 32'(cyc - last_change), 32'(HOLDOFF));
                last_change = cyc; prev = commited_rd_addr;
            end
        end
        idle(20);
        chk("spacing_final", 32'(commited_rd_addr), 32'h1E0);

        // Contention: round-robin alternation
        do_reset();
        r0 = 2; r1 = 2;
        for (int i = 0; i < 16 && (r0 > 0 || r1 > 0); i++) begin
            step(r0 > 0, 8'd1, r1 > 0, 8'd2, 0, g0, g1);
            if (g0) begin grants.push_back(0); r0--; end
            if (g1) begin grants.push_back(1); r1--; end
        end
        chk("rr_count", 32'(grants.size()), 32'd4);
        for (int i = 0; i < grants.size() && i < 4; i++) chk("rr_order", 32'(grants[i]), 32'(i % 2));
        idle(10);
        chk("rr_acc", 32'(commited_rd_addr), 32'd6);

        // Wrap
        do_reset();
        for (int i = 0; i < 16; i++) send(0, 8'hFF);
        idle(12);
        chk("wrap_preload", 32'(commited_rd_addr), 32'hFF0);
        send(1, 8'h20);
        idle(12);
        chk("wrap", 32'(commited_rd_addr), 32'h010);

        // Full guard
        do_reset();
        saw_block = 0; saw_reassert = 0;
        for (int i = 0; i < 24; i++) begin
            step(1, 8'hFF, 0, '0, 0, g0, g1);
            if (!last_r0) saw_block = 1;
            else if (saw_block) saw_reassert = 1;
        end
        chk("full_block_seen", 32'(saw_block), 32'd1);
        chk("full_reassert_seen", 32'(saw_reassert), 32'd1);
        idle(12);

        // Flush republishes and restarts holdoff
        do_reset();
        send(0, 8'h30);
        idle(12);
        step(0, '0, 0, '0, 1, g0, g1);
        idle(1);
        send(0, 8'h10);
        idle(2);
        chk("flush_holds", 32'(commited_rd_addr), 32'h030);
        idle(10);
        chk("flush_after", 32'(commited_rd_addr), 32'h040);

        // Reset during holdoff
        do_reset();
        send(0, 8'h50);
        idle(2);
        chk("hold_before_rst", 32'(commited_rd_addr), 32'h050);
        do_reset();
        send(0, 8'h08);
        idle(1);
        chk("rst_idle_publish", 32'(commited_rd_addr), 32'h008);

        // Randomized traffic with holding requesters
        do_reset();
        a0 = 0; a1 = 0; q0 = '0; q1 = '0;
        for (int i = 0; i < 3000; i++) begin
            if (!a0 && $urandom_range(0, 9) < 6) begin a0 = 1; q0 = LW'($urandom); end
            if (!a1 && $urandom_range(0, 9) < 6) begin a1 = 1; q1 = ($urandom_range(0, 7) == 0) ? '0 : LW'($urandom); end
            step(a0, q0, a1, q1, $urandom_range(0, 19) == 0, g0, g1);
            if (g0) a0 = 0;
            if (g1) a1 = 0;
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
                a0 = 0; a1 = 0;
            end
        end
        idle(12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
